// File: rtl/pipe_addsub_if.sv
// Purpose: operand/result handshake bundle for pipe_addsub.
// Ports (signals):
//   in_valid/in_ready, a, b, cin, sub     : operand issue side
//   out_valid/out_ready, result, cout,
//   ovf, zero                             : result writeback side
// master = issuer/consumer view, slave = the adder's view.
interface pipe_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_addsub.sv
// Purpose: WIDTH-bit add/subtract unit, carry-pipelined over STAGES slices.
//   Each stage adds one WIDTH/STAGES-bit slice and registers the carry for the
//   next stage; one operation per clock, result STAGES edges after issue.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active-low
//   bus    : pipe_addsub_if.slave (operand valid/ready in, result valid/ready out)
module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_addsub_if.slave bus
);
  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  // Per-stage token: valid, carry out of the slices done so far, the
  // operand-A word with finished slices replaced by result bits, and the
  // conditioned operand B.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  bb_q  [STAGES];
  logic [WIDTH-1:0]  bb_d  [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [STAGES-1:0] hole;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [WIDTH-1:0]  acc_src [STAGES];
  logic [WIDTH-1:0]  bb_src  [STAGES];
  logic [SLICE:0]    sum;

  assign hole = ~v_q;

  // A stage loads if any stage at or after it is empty, or the output drains;
  // this lets bubbles collapse under a downstream stall.
  always_comb begin
    load = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      load[k] = bus.out_ready | (|(hole >> k));
    end
  end

  // Stage inputs: conditioned operands for stage 0, previous stage otherwise.
  always_comb begin
    v_src      = '0;
    c_src      = '0;
    acc_src    = acc_q;
    bb_src     = bb_q;
    v_src[0]   = bus.in_valid;
    c_src[0]   = bus.sub ^ bus.cin;
    acc_src[0] = bus.a;
    bb_src[0]  = bus.sub ? ~bus.b : bus.b;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_src[k]   = v_q[k-1];
      c_src[k]   = c_q[k-1];
      acc_src[k] = acc_q[k-1];
      bb_src[k]  = bb_q[k-1];
    end
  end

  // Slice adders and next-state for every stage.
  always_comb begin
    v_d    = v_q;
    c_d    = c_q;
    acc_d  = acc_q;
    bb_d   = bb_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    sum    = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      sum = {1'b0, acc_src[k][k*SLICE +: SLICE]}
          + {1'b0, bb_src[k][k*SLICE +: SLICE]}
          + {{SLICE{1'b0}}, c_src[k]};
      if (load[k]) begin
        v_d[k]                    = v_src[k];
        c_d[k]                    = sum[SLICE];
        acc_d[k]                  = acc_src[k];
        acc_d[k][k*SLICE +: SLICE] = sum[SLICE-1:0];
        bb_d[k]                   = bb_src[k];
        // Flags are formed as the top slice completes, from the operand signs.
        if (k == int'(LAST)) begin
          ovf_d  = (acc_src[k][WIDTH-1] == bb_src[k][WIDTH-1]) &
                   (acc_d[k][WIDTH-1] != acc_src[k][WIDTH-1]);
          zero_d = (acc_d[k] == '0);
        end
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        acc_q[k] <= '0;
        bb_q[k]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        acc_q[k] <= acc_d[k];
        bb_q[k]  <= bb_d[k];
      end
    end
  end

  // in_ready is forced low while reset is asserted.
  assign bus.in_ready  = rst_n & load[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.result    = acc_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Purpose: self-checking bench for pipe_addsub with STAGES = 4, 1 and WIDTH.
//   One DUT is selected at a time; the others see no valid input.
module tb_pipe_addsub;
  localparam int unsigned W = 32;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(W)) bus4 ();
  pipe_addsub_if #(.WIDTH(W)) bus1 ();
  pipe_addsub_if #(.WIDTH(W)) bus32 ();

  pipe_addsub #(.WIDTH(W), .STAGES(4)) u_s4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipe_addsub #(.WIDTH(W), .STAGES(1)) u_s1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_addsub #(.WIDTH(W), .STAGES(W)) u_s32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  int             sel;
  logic           d_valid, d_cin, d_sub, d_oready;
  logic [W-1:0]   d_a, d_b;

  assign bus4.in_valid  = d_valid && (sel == 0);
  assign bus1.in_valid  = d_valid && (sel == 1);
  assign bus32.in_valid = d_valid && (sel == 2);
  assign bus4.a  = d_a;   assign bus1.a  = d_a;   assign bus32.a  = d_a;
  assign bus4.b  = d_b;   assign bus1.b  = d_b;   assign bus32.b  = d_b;
  assign bus4.cin = d_cin; assign bus1.cin = d_cin; assign bus32.cin = d_cin;
  assign bus4.sub = d_sub; assign bus1.sub = d_sub; assign bus32.sub = d_sub;
  assign bus4.out_ready  = d_oready;
  assign bus1.out_ready  = d_oready;
  assign bus32.out_ready = d_oready;

  logic         o_valid [NDUT];
  logic         o_iready[NDUT];
  logic         o_cout  [NDUT];
  logic         o_ovf   [NDUT];
  logic         o_zero  [NDUT];
  logic [W-1:0] o_res   [NDUT];

  assign o_valid[0] = bus4.out_valid;  assign o_valid[1] = bus1.out_valid;  assign o_valid[2] = bus32.out_valid;
  assign o_iready[0] = bus4.in_ready;  assign o_iready[1] = bus1.in_ready;  assign o_iready[2] = bus32.in_ready;
  assign o_cout[0] = bus4.cout;        assign o_cout[1] = bus1.cout;        assign o_cout[2] = bus32.cout;
  assign o_ovf[0] = bus4.ovf;          assign o_ovf[1] = bus1.ovf;          assign o_ovf[2] = bus32.ovf;
  assign o_zero[0] = bus4.zero;        assign o_zero[1] = bus1.zero;        assign o_zero[2] = bus32.zero;
  assign o_res[0] = bus4.result;       assign o_res[1] = bus1.result;       assign o_res[2] = bus32.result;

  int lat [NDUT] = '{4, 1, 32};
  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t tbl [12];
  logic [W+2:0] exp_q [$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (stages=%0d): got %h expected %h", name, lat[sel], got, exp);
    end
  endtask

  // Reference: result = a + bb + c0 with conditioned operands; {cout, ovf, zero, result}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   s;
    logic         ovf;
    bb  = sub ? ~b : b;
    c0  = sub ? ~cin : cin;
    s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {s[W], ovf, (s[W-1:0] == '0), s[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    d_valid = v; d_a = a; d_b = b; d_cin = cin; d_sub = sub;
  endtask

  task automatic compare_out(input string name, input logic [W+2:0] e);
    check({name, "_result"}, o_res[sel], e[W-1:0]);
    check({name, "_cout"},   W'(o_cout[sel]), W'(e[W+2]));
    check({name, "_ovf"},    W'(o_ovf[sel]),  W'(e[W+1]));
    check({name, "_zero"},   W'(o_zero[sel]), W'(e[W]));
  endtask

  // Directed vectors, one at a time, with latency measured from the capture edge.
  task automatic run_table();
    int cyc;
    d_oready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      #1;
      check("tbl_in_ready", W'(o_iready[sel]), W'(1));
      step();
      d_valid = 1'b0;
      cyc = 1;
      while (!o_valid[sel] && cyc < 100) begin
        step();
        cyc++;
      end
      check("tbl_latency", W'(cyc), W'(lat[sel]));
      compare_out("tbl", {tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].res});
      step();
      check("tbl_drained", W'(o_valid[sel]), W'(0));
    end
  endtask

  // Back-to-back random stream with out_ready held high.
  task automatic stream_test(input int n);
    logic [W-1:0] ra [10];
    logic [W-1:0] rb [10];
    logic         rc [10];
    logic         rs [10];
    int idx, got, cyc, last;
    idx = 0; got = 0; cyc = 0; last = 0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      ra[i] = $urandom; rb[i] = $urandom;
      rc[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
    end
    d_oready = 1'b1;
    while (got < n && cyc < 300) begin
      if (idx < n) drive(1'b1, ra[idx], rb[idx], rc[idx], rs[idx]);
      else d_valid = 1'b0;
      #1;
      if (d_valid) begin
        check("stream_in_ready", W'(o_iready[sel]), W'(1));
        if (o_iready[sel]) begin
          exp_q.push_back(model(ra[idx], rb[idx], rc[idx], rs[idx]));
          idx++;
        end
      end
      if (o_valid[sel]) begin
        if (exp_q.size() == 0) check("stream_spurious", W'(o_valid[sel]), W'(0));
        else begin
          compare_out("stream", exp_q.pop_front());
          if (got > 0) check("stream_gap", W'(cyc), W'(last + 1));
          last = cyc;
          got++;
        end
      end
      step();
      cyc++;
    end
    d_valid = 1'b0;
    check("stream_count", W'(got), W'(n));
  endtask

  // Stall the output while issuing: the pipe fills to STAGES tokens and holds.
  task automatic hold_test();
    int n_acc, cyc;
    logic [W-1:0] ha, hb;
    logic hc, hs;
    n_acc = 0;
    exp_q.delete();
    d_oready = 1'b0;
    for (int c = 0; c < lat[sel] + 2; c++) begin
      ha = $urandom; hb = $urandom;
      hc = 1'($urandom_range(0, 1)); hs = 1'($urandom_range(0, 1));
      drive(1'b1, ha, hb, hc, hs);
      #1;
      if (o_iready[sel]) begin
        exp_q.push_back(model(ha, hb, hc, hs));
        n_acc++;
      end
      step();
    end
    d_valid = 1'b0;
    #1;
    check("hold_accepts",   W'(n_acc), W'(lat[sel]));
    check("hold_in_ready",  W'(o_iready[sel]), W'(0));
    check("hold_out_valid", W'(o_valid[sel]), W'(1));
    if (exp_q.size() > 0) compare_out("hold_head", exp_q[0]);
    d_oready = 1'b1;
    #1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (o_valid[sel]) compare_out("hold_drain", exp_q.pop_front());
      step();
      cyc++;
    end
    check("hold_left", W'(exp_q.size()), W'(0));
    check("hold_in_ready_back", W'(o_iready[sel]), W'(1));
    check("hold_empty", W'(o_valid[sel]), W'(0));
  endtask

  // Reset with tokens in flight: nothing stale may emerge afterwards.
  task automatic reset_test();
    d_oready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h0000_0010 + W'(c), 32'h0000_0003, 1'b0, 1'b0);
      #1;
      step();
    end
    d_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_low", W'(o_iready[sel]), W'(0));
    step();
    check("rst_out_valid", W'(o_valid[sel]), W'(0));
    check("rst_result",    o_res[sel], W'(0));
    check("rst_cout",      W'(o_cout[sel]), W'(0));
    check("rst_ovf",       W'(o_ovf[sel]),  W'(0));
    check("rst_zero",      W'(o_zero[sel]), W'(0));
    rst_n = 1'b1;
    d_oready = 1'b1;
    #1;
    check("rst_in_ready_release", W'(o_iready[sel]), W'(1));
    for (int c = 0; c < lat[sel] + 2; c++) begin
      check("rst_no_stale", W'(o_valid[sel]), W'(0));
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //          a             b             cin   sub   result        cout  ovf   zero
    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

    sel = 0;
    rst_n = 1'b0;
    d_oready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      check("reset_out_valid", W'(o_valid[sel]), W'(0));
      check("reset_result",    o_res[sel], W'(0));
      check("reset_flags",     W'({o_cout[sel], o_ovf[sel], o_zero[sel]}), W'(0));
      check("reset_in_ready",  W'(o_iready[sel]), W'(0));
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      check("release_in_ready", W'(o_iready[sel]), W'(1));
    end
    step();

    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      run_table();
      stream_test(10);
      hold_test();
      reset_test();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
